// File: rtl/bitstream_match_sched_pkg.sv
// Shared types and sizes for the "101" match scheduler and its detector.
package bitstream_match_sched_pkg;

    localparam int MSG_W = 8;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } ctrl_state_t;

    typedef enum logic [1:0] {
        DET_A = 2'd0,
        DET_B = 2'd1,
        DET_C = 2'd2,
        DET_D = 2'd3
    } det_state_t;

endpackage

// File: rtl/pattern101_det.sv
// Moore detector for the serial pattern "101" with overlap; out is high only in state D.
module pattern101_det
    import bitstream_match_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       in_,
    output logic [1:0] state,
    output logic       out
);

    det_state_t state_q, state_d;

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            DET_A: state_d = in_ ? DET_B : DET_A;
            DET_B: state_d = in_ ? DET_B : DET_C;
            DET_C: state_d = in_ ? DET_D : DET_A;
            DET_D: state_d = in_ ? DET_B : DET_C;
        endcase
        if (clear) state_d = DET_A;
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so all state updates see pre-edge values.
        if (reset) state_q <= DET_A;
        else       state_q <= state_d;
    end

    assign state = state_q;
    assign out   = (state_q == DET_D);

endmodule

// File: rtl/bitstream_match_sched.sv
// Round-robin scheduler sharing one "101" detector between two requesters; returns per-word match counts.
module bitstream_match_sched
    import bitstream_match_sched_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_val,
    output logic             req0_rdy,
    input  logic [MSG_W-1:0] req0_msg,
    input  logic             req1_val,
    output logic             req1_rdy,
    input  logic [MSG_W-1:0] req1_msg,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [CNT_W:0]   resp_msg
);

    localparam logic [2:0] LAST_IDX = 3'(MSG_W - 1);

    ctrl_state_t      state_q, state_d;
    logic [MSG_W-1:0] msg_q;
    logic             id_q;
    logic             ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [2:0]       idx_q;

    logic gnt, accept, det_clear, det_in, det_out;
    logic [1:0] det_state;

    pattern101_det u_det (
        .clk   (clk),
        .reset (reset),
        .clear (det_clear),
        .in_   (det_in),
        .state (det_state),
        .out   (det_out)
    );

    // Pointer only breaks ties; a lone requester always wins.
    assign gnt = (req0_val && req1_val) ? ptr_q : req1_val;

    always_comb begin
        state_d   = state_q;
        req0_rdy  = 1'b0;
        req1_rdy  = 1'b0;
        accept    = 1'b0;
        det_clear = 1'b0;
        det_in    = 1'b0;
        resp_val  = 1'b0;
        unique case (state_q)
            IDLE: begin
                req0_rdy = !reset && req0_val && !gnt;
                req1_rdy = !reset && req1_val &&  gnt;
                accept   = req0_rdy || req1_rdy;
                if (accept) begin
                    det_clear = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                det_in = msg_q[LAST_IDX - idx_q];
                if (idx_q == LAST_IDX) state_d = DRAIN;
            end
            DRAIN: state_d = RESP;
            RESP: begin
                resp_val = 1'b1;
                if (resp_rdy) state_d = IDLE;
            end
        endcase
        resp_msg = resp_val ? {id_q, count_q} : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            msg_q   <= '0;
            id_q    <= 1'b0;
            ptr_q   <= 1'b0;
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                msg_q   <= gnt ? req1_msg : req0_msg;
                id_q    <= gnt;
                ptr_q   <= !gnt;
                count_q <= '0;
                idx_q   <= '0;
            end
            // Moore output lags its input by one cycle, so DRAIN collects the final bit's match.
            if (state_q == SHIFT || state_q == DRAIN)
                count_q <= count_q + {{(CNT_W-1){1'b0}}, det_out};
            if (state_q == SHIFT)
                idx_q <= idx_q + 3'd1;
        end
    end

endmodule
